vector_sequencer: RTL

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

---
 rtl/vector_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vector_sequencer.sv
// Vector sequencer: steps through a loaded table of {Valid, Expect, Mask, Ctrl}
// entries, drives each Ctrl word, waits SETTLE+1 cycles, then compares the masked observation.
module vector_sequencer #(
  parameter int CTRL_W      = 40,
  parameter int OBS_W       = 8,
  parameter int DEPTH       = 256,
  parameter int SETTLE      = 1,
  parameter int STOP_ON_ERR = 0,
  parameter int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Pause,
  input  logic                        Load_En,
  input  logic [ADDR_W-1:0]           Load_Addr,
  input  logic [1+2*OBS_W+CTRL_W-1:0] Load_Data,
  input  logic [OBS_W-1:0]            Obs_In,
  output logic [CTRL_W-1:0]           Ctrl_Out,
  output logic [ADDR_W-1:0]           Vector_Num,
  output logic                        Busy,
  output logic                        Done,
  output logic [15:0]                 Error_Count,
  output logic                        Fail_Valid,
  output logic [ADDR_W-1:0]           Fail_Index
);

  localparam int ENTRY_W = 1 + 2*OBS_W + CTRL_W;
  localparam int CNT_W   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_r, state_next;

  // Valid bits live apart from the payload so reset can clear them alone.
  logic [ENTRY_W-2:0] mem_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [CNT_W-1:0]   settle_cnt_r;

  logic [ENTRY_W-2:0] entry_s;
  logic [CTRL_W-1:0]  ctrl_s;
  logic [OBS_W-1:0]   mask_s;
  logic [OBS_W-1:0]   expect_s;
  logic               busy_s;
  logic               load_ok_s;
  logic               mismatch_s;
  logic               stop_s;
  logic               last_s;

  assign entry_s    = mem_r[Vector_Num];
  assign ctrl_s     = entry_s[CTRL_W-1:0];
  assign mask_s     = entry_s[CTRL_W +: OBS_W];
  assign expect_s   = entry_s[CTRL_W+OBS_W +: OBS_W];
  assign busy_s     = (state_r == S_FETCH) || (state_r == S_SETTLE) || (state_r == S_CHECK);
  assign load_ok_s  = Load_En && !busy_s;
  assign mismatch_s = |((Obs_In ^ expect_s) & mask_s);
  assign stop_s     = mismatch_s && (STOP_ON_ERR != 0);
  assign last_s     = (Vector_Num == LAST_IDX);

  // Next-state selection; Pause freezes only the busy states.
  always_comb begin
    state_next = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (Start) state_next = S_FETCH;
        else       state_next = state_r;
      end
      S_FETCH: begin
        if (Pause)                        state_next = S_FETCH;
        else if (!valid_r[Vector_Num])    state_next = S_DONE;
        else                              state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (Pause)                        state_next = S_SETTLE;
        else if (settle_cnt_r == '0)      state_next = S_CHECK;
        else                              state_next = S_SETTLE;
      end
      S_CHECK: begin
        if (Pause)                        state_next = S_CHECK;
        else if (stop_s || last_s)        state_next = S_DONE;
        else                              state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register with Busy/Done decoded from the next state so they stay registered.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_r <= state_next;
      Busy    <= (state_next == S_FETCH) || (state_next == S_SETTLE) || (state_next == S_CHECK);
      Done    <= (state_next == S_DONE);
    end
  end

  // Run datapath: index, settle counter, control word and mismatch bookkeeping.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Ctrl_Out     <= '0;
      Vector_Num   <= '0;
      Error_Count  <= 16'd0;
      Fail_Valid   <= 1'b0;
      Fail_Index   <= '0;
      settle_cnt_r <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (Start) begin
            Vector_Num  <= '0;
            Error_Count <= 16'd0;
            Fail_Valid  <= 1'b0;
            Fail_Index  <= '0;
          end
        end
        S_FETCH: begin
          if (!Pause && valid_r[Vector_Num]) begin
            Ctrl_Out     <= ctrl_s;
            settle_cnt_r <= CNT_W'(SETTLE);
          end
        end
        S_SETTLE: begin
          if (!Pause && (settle_cnt_r != '0)) settle_cnt_r <= settle_cnt_r - CNT_W'(1);
        end
        S_CHECK: begin
          if (!Pause) begin
            if (mismatch_s) begin
              if (Error_Count != 16'hFFFF) Error_Count <= Error_Count + 16'd1;
              if (!Fail_Valid) begin
                Fail_Valid <= 1'b1;
                Fail_Index <= Vector_Num;
              end
            end
            if (!stop_s && !last_s) Vector_Num <= Vector_Num + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Valid bits: cleared by reset, written only while the sequencer is not running.
  always_ff @(posedge Clock) begin
    if (!Reset)         valid_r <= '0;
    else if (load_ok_s) valid_r[Load_Addr] <= Load_Data[ENTRY_W-1];
  end

  // Payload storage carries no reset.
  always_ff @(posedge Clock) begin
    if (Reset && load_ok_s) mem_r[Load_Addr] <= Load_Data[ENTRY_W-2:0];
  end

endmodule
